// File: rtl/pulse_pkg.sv
// Shared encodings and helpers for the pulse stretcher.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Bits needed to hold the value n; at least one so a zero hold-off still elaborates.
  function automatic int hold_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pulse_down_counter.sv
// Loadable down counter that saturates at zero; reports when it has reached zero.
module pulse_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load has priority over decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a trigger strobe into a registered pulse of len cycles, followed by a hold-off gap.
// Define RETRIGGER_EN to let a trigger during an active pulse restart its length.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trig,
  input  logic [WIDTH-1:0] len,
  input  logic             clr,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [1:0]       dbg_state
);

  localparam int HW = hold_width(HOLDOFF);

  state_e state_q, state_d;
  logic   out_q, out_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   overrun_q, overrun_d;

  logic   len_load, len_dec, len_zero;
  logic   hold_load, hold_dec, hold_zero;
  logic   drop, retrig;

  pulse_down_counter #(.WIDTH(WIDTH)) u_len_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (len_load),
    .load_val (len - WIDTH'(1)),
    .dec      (len_dec),
    .zero     (len_zero)
  );

  // The hold-off counter is loaded with HOLDOFF on the completion edge, so the
  // done cycle is followed by HOLDOFF further low, busy cycles.
  pulse_down_counter #(.WIDTH(HW)) u_hold_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (hold_load),
    .load_val (HW'(HOLDOFF)),
    .dec      (hold_dec),
    .zero     (hold_zero)
  );

  always_comb begin
    state_d   = state_q;
    out_d     = FALSE;
    done_d    = FALSE;
    len_load  = FALSE;
    len_dec   = FALSE;
    hold_load = FALSE;
    hold_dec  = FALSE;
    drop      = FALSE;
    retrig    = FALSE;

    case (state_q)
      ST_IDLE: begin
        if (trig && (len != '0)) begin
          state_d  = ST_ACTIVE;
          len_load = TRUE;
          out_d    = TRUE;
        end
      end

      ST_ACTIVE: begin
`ifdef RETRIGGER_EN
        retrig = trig && (len != '0);
`else
        drop   = trig;
`endif
        // A retrigger on the final edge takes precedence over completion.
        if (retrig) begin
          len_load = TRUE;
          out_d    = TRUE;
        end else if (len_zero) begin
          done_d = TRUE;
          if (HOLDOFF > 0) begin
            state_d   = ST_HOLDOFF;
            hold_load = TRUE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          len_dec = TRUE;
          out_d   = TRUE;
        end
      end

      ST_HOLDOFF: begin
        drop = trig;
        if (hold_zero) begin
          state_d = ST_IDLE;
        end else begin
          hold_dec = TRUE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    overrun_d = drop ? TRUE : (clr ? FALSE : overrun_q);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      out_q     <= FALSE;
      busy_q    <= FALSE;
      done_q    <= FALSE;
      overrun_q <= FALSE;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed and random bench for pulse_stretcher; two instances (16-bit/hold-off 2, 4-bit/no hold-off).
module tb_pulse_stretcher;
  import pulse_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trig = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] len = '0;
  logic [3:0]  len_b;

  logic       a_out, a_busy, a_done, a_ovr;
  logic       b_out, b_busy, b_done, b_ovr;
  logic [1:0] a_dbg, b_dbg;

  assign len_b = len[3:0];

  pulse_stretcher #(.WIDTH(16), .HOLDOFF(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .trig(trig), .len(len), .clr(clr),
    .out(a_out), .busy(a_busy), .done(a_done), .overrun(a_ovr), .dbg_state(a_dbg)
  );

  pulse_stretcher #(.WIDTH(4), .HOLDOFF(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .trig(trig), .len(len_b), .clr(clr),
    .out(b_out), .busy(b_busy), .done(b_done), .overrun(b_ovr), .dbg_state(b_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  int         check_n = 0;
  int         err_n   = 0;
  longint     edge_n  = 0;
  logic [3:0] exp_q[$];

  // Reference model: each pulse is described by the edge it ends on and the
  // last edge after which the block still reports busy.
  longint end_e[2];
  longint busy_last[2];
  bit     ovr_m[2];
  int     hold_of[2] = '{2, 0};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      end_e[i]     = -1000;
      busy_last[i] = -1000;
      ovr_m[i]     = 1'b0;
    end
  endtask

  task automatic schedule(input int id, input longint m, input logic [15:0] l);
    end_e[id]     = m + longint'(l);
    busy_last[id] = end_e[id] - 1 + ((hold_of[id] > 0) ? hold_of[id] + 1 : 0);
  endtask

  task automatic model_edge(input int id, input logic t, input logic [15:0] l_in, input logic c);
    logic [15:0] l;
    longint      m;
    bit          idle, active, drop;
    l      = (id == 0) ? l_in : (l_in & 16'h000F);
    m      = edge_n;
    idle   = (m > busy_last[id] + 1);
    active = !idle && (m <= end_e[id]);
    drop   = 1'b0;
    if (idle) begin
      if (t && (l != 0)) schedule(id, m, l);
    end else if (active) begin
`ifdef RETRIGGER_EN
      if (t && (l != 0)) schedule(id, m, l);
`else
      if (t) drop = 1'b1;
`endif
    end else begin
      if (t) drop = 1'b1;
    end
    ovr_m[id] = drop ? 1'b1 : (c ? 1'b0 : ovr_m[id]);
    exp_q.push_back({m < end_e[id], m <= busy_last[id], m == end_e[id], ovr_m[id]});
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    check_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
    end
  endtask

  // Driver: apply inputs on the falling edge, advance the model on the rising edge, check 1 ns later.
  task automatic step(input logic t, input logic [15:0] l, input logic c);
    logic [3:0] e;
    @(negedge clk);
    trig = t;
    len  = l;
    clr  = c;
    @(posedge clk);
    model_edge(0, t, l, c);
    model_edge(1, t, l, c);
    edge_n++;
    #1;
    e = exp_q.pop_front();
    check4("dut_a{out,busy,done,ovr}", {a_out, a_busy, a_done, a_ovr}, e);
    e = exp_q.pop_front();
    check4("dut_b{out,busy,done,ovr}", {b_out, b_busy, b_done, b_ovr}, e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'($urandom), 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check4({tag, "_a"}, {a_out, a_busy, a_done, a_ovr}, 4'b0000);
    check4({tag, "_b"}, {b_out, b_busy, b_done, b_ovr}, 4'b0000);
    check4({tag, "_a_state"}, {2'b00, a_dbg}, {2'b00, ST_IDLE});
    check4({tag, "_b_state"}, {2'b00, b_dbg}, {2'b00, ST_IDLE});
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Basic pulse: len=5 with hold-off timing
    step(1'b1, 16'd5, 1'b0);
    idle(12);

    // len=0 trigger is ignored
    step(1'b1, 16'd0, 1'b0);
    idle(20);

    // Trigger while active, clear, then trigger in hold-off together with clear
    step(1'b1, 16'd8, 1'b0);
    idle(2);
    step(1'b1, 16'd3, 1'b0);
    idle(5);
    step(1'b0, 16'd0, 1'b1);
    step(1'b1, 16'd0, 1'b1);
    idle(4);
    step(1'b0, 16'd0, 1'b1);
    idle(2);

    // Retrigger case: len=8 then len=4 six edges later
    step(1'b1, 16'd8, 1'b0);
    idle(5);
    step(1'b1, 16'd4, 1'b0);
    idle(10);
    step(1'b0, 16'd0, 1'b1);

    // Maximum length on the 4-bit instance, then trigger on its done cycle
    step(1'b1, 16'd15, 1'b0);
    idle(15);
    step(1'b1, 16'd3, 1'b0);
    idle(8);

    // Asynchronous reset in the middle of an active pulse
    step(1'b1, 16'd10, 1'b0);
    idle(3);
    reset_n = 1'b0;
    trig    = 1'b0;
    clr     = 1'b0;
    #1;
    check_reset_state("mid_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    check_reset_state("after_reset");

    // Random traffic
    repeat (400) begin
      step(1'($urandom_range(0, 3) == 0), 16'($urandom_range(0, 12)), 1'($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", check_n, err_n);
    $finish;
  end

endmodule
